// File: rtl/reg_text_writer.sv
// Walks the 32 register values and streams each one as a 16-character text line
// ("xNN=HHHHHHHH    ") into the character buffer, one character per accepted write.
module reg_text_writer #(
  parameter int BASE_ADDR = 0,
  parameter int ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       regs_in [0:31],
  input  logic              char_ready,
  output logic              char_we,
  output logic [ADDR_W-1:0] char_addr,
  output logic [7:0]        char_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_r;
  logic [4:0]  line_r;
  logic [3:0]  col_r;
  logic [31:0] snap_r;

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    logic [7:0] c;
    if (nib < 4'd10) begin
      c = 8'h30 + {4'h0, nib};
    end else begin
      c = 8'h37 + {4'h0, nib};
    end
    return c;
  endfunction

  function automatic logic [7:0] text_char(input logic [4:0] k, input logic [3:0] col,
                                           input logic [31:0] snap);
    logic [1:0] tens;
    logic [4:0] ones;
    logic [3:0] idx;
    logic [3:0] nib;
    logic [7:0] c;
    tens = (k >= 5'd30) ? 2'd3 : (k >= 5'd20) ? 2'd2 : (k >= 5'd10) ? 2'd1 : 2'd0;
    ones = k - 5'd10 * {3'd0, tens};
    // Column 4 carries bits [31:28], column 11 bits [3:0].
    idx  = 4'd11 - col;
    nib  = 4'(snap >> {idx[2:0], 2'b00});
    case (col)
      4'd0:    c = 8'h78;
      4'd1:    c = 8'h30 + {6'd0, tens};
      4'd2:    c = 8'h30 + {3'd0, ones};
      4'd3:    c = 8'h3D;
      4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11:
               c = hex_char(nib);
      default: c = 8'h20;
    endcase
    return c;
  endfunction

  function automatic logic [ADDR_W-1:0] addr_of(input logic [4:0] k, input logic [3:0] col);
    return ADDR_W'(BASE_ADDR) + ADDR_W'({k, col});
  endfunction

  // Pass sequencer; outputs are loaded alongside the state they belong to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      line_r    <= 5'd0;
      col_r     <= 4'd0;
      snap_r    <= 32'd0;
      char_we   <= 1'b0;
      char_addr <= '0;
      char_data <= 8'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state_r <= LOAD;
            line_r  <= 5'd0;
            busy    <= 1'b1;
          end
        end
        LOAD: begin
          snap_r    <= regs_in[line_r];
          col_r     <= 4'd0;
          char_we   <= 1'b1;
          char_addr <= addr_of(line_r, 4'd0);
          char_data <= 8'h78;
          state_r   <= WRITE;
        end
        WRITE: begin
          // A stalled write simply holds every register.
          if (char_ready) begin
            if (col_r != 4'd15) begin
              col_r     <= col_r + 4'd1;
              char_addr <= addr_of(line_r, col_r + 4'd1);
              char_data <= text_char(line_r, col_r + 4'd1, snap_r);
            end else begin
              char_we <= 1'b0;
              if (line_r != 5'd31) begin
                line_r  <= line_r + 5'd1;
                state_r <= LOAD;
              end else begin
                state_r <= DONE;
                done    <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          char_we <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_text_writer.sv
// Bench for reg_text_writer: a pass-position model predicts every cycle's outputs
// for two instances (base 0 and base 1000), plus directed literal checks.
module tb_reg_text_writer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        char_ready;
  logic [31:0] regs [0:31];

  logic        we1, busy1, done1;
  logic [9:0]  addr1;
  logic [7:0]  data1;
  logic        we2, busy2, done2;
  logic [9:0]  addr2;
  logic [7:0]  data2;

  reg_text_writer #(.BASE_ADDR(0), .ADDR_W(10)) dut (
    .clk(clk), .reset(reset), .start(start), .regs_in(regs), .char_ready(char_ready),
    .char_we(we1), .char_addr(addr1), .char_data(data1), .busy(busy1), .done(done1));

  reg_text_writer #(.BASE_ADDR(1000), .ADDR_W(10)) dut_wrap (
    .clk(clk), .reset(reset), .start(start), .regs_in(regs), .char_ready(char_ready),
    .char_we(we2), .char_addr(addr2), .char_data(data2), .busy(busy2), .done(done2));

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] exp_snap [0:31];
  logic [7:0]  mem  [0:1023];
  logic [7:0]  mem2 [0:1023];
  int writes, done_cnt, done_cyc, pass_cyc, first_addr, wrap_pos;
  bit m_on;
  int m_e;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] fmt(input int k, input int col, input logic [31:0] v);
    string s, h;
    h = $sformatf("%08h", v);
    h = h.toupper();
    s = {"x", $sformatf("%02d", k), "=", h, "    "};
    return s[col];
  endfunction

  // Model: a pass is 545 effective cycles; line k loads at 1+17k, writes follow,
  // done at 545; a stalled write cycle does not advance the position.
  initial begin : compare
    bit e_we, e_done;
    int k, col, r;
    logic [9:0] e_a1, e_a2;
    logic [7:0] e_d;
    m_on = 1'b0;
    m_e = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("rst_we", {31'd0, we1}, 32'd0);
        chk("rst_busy", {31'd0, busy1}, 32'd0);
        chk("rst_done", {31'd0, done1}, 32'd0);
        chk("rst_addr", {22'd0, addr1}, 32'd0);
        chk("rst_data", {24'd0, data1}, 32'd0);
        chk("rst_we2", {31'd0, we2}, 32'd0);
        m_on = 1'b0;
      end else begin
        e_we = 1'b0;
        e_done = 1'b0;
        e_a1 = 10'd0; e_a2 = 10'd0; e_d = 8'd0; k = 0; col = 0;
        if (m_on) begin
          pass_cyc++;
          if (m_e == 545) begin
            e_done = 1'b1;
          end else begin
            r = (m_e - 1) % 17;
            k = (m_e - 1) / 17;
            if (r != 0) begin
              e_we = 1'b1;
              col = r - 1;
              e_a1 = 10'((16 * k + col) % 1024);
              e_a2 = 10'((1000 + 16 * k + col) % 1024);
              e_d = fmt(k, col, exp_snap[k]);
            end
          end
        end
        chk("we", {31'd0, we1}, {31'd0, e_we});
        chk("busy", {31'd0, busy1}, {31'd0, m_on});
        chk("done", {31'd0, done1}, {31'd0, e_done});
        chk("we2", {31'd0, we2}, {31'd0, e_we});
        chk("busy2", {31'd0, busy2}, {31'd0, m_on});
        chk("done2", {31'd0, done2}, {31'd0, e_done});
        if (e_we) begin
          chk("addr", {22'd0, addr1}, {22'd0, e_a1});
          chk("data", {24'd0, data1}, {24'd0, e_d});
          chk("addr2", {22'd0, addr2}, {22'd0, e_a2});
          chk("data2", {24'd0, data2}, {24'd0, e_d});
        end
        if (we1 && char_ready) begin
          writes++;
          mem[addr1] = data1;
          if (first_addr < 0) first_addr = int'(addr1);
        end
        if (we2 && char_ready) begin
          mem2[addr2] = data2;
          if (addr2 == 10'd0 && e_we) wrap_pos = 16 * k + col;
        end
        if (done1) begin
          done_cnt++;
          done_cyc = pass_cyc;
        end
        if (m_on) begin
          if (e_we && !char_ready) begin
            m_e = m_e;
          end else if (m_e == 545) begin
            m_on = 1'b0;
          end else begin
            m_e++;
          end
        end else if (start) begin
          m_on = 1'b1;
          m_e = 1;
          pass_cyc = 0;
          first_addr = -1;
        end
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic start_pulse();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic clear_counts();
    writes = 0;
    done_cnt = 0;
    done_cyc = 0;
  endtask

  task automatic wait_done();
    int target;
    bit seen;
    target = done_cnt + 1;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      step(1);
      if (done_cnt >= target) seen = 1'b1;
    end
    chk("done_timeout", {31'd0, seen}, 32'd1);
    step(2);
  endtask

  initial begin : stimulus
    string exp5;
    exp5 = "x05=DEADBEEF    ";
    reset = 1'b0;
    start = 1'b0;
    char_ready = 1'b1;
    writes = 0; done_cnt = 0; done_cyc = 0; pass_cyc = 0; first_addr = -1; wrap_pos = -1;
    for (int i = 0; i < 32; i++) begin
      regs[i] = 32'd0;
      exp_snap[i] = 32'd0;
    end
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 8'd0;
      mem2[i] = 8'd0;
    end
    step(3);
    chk("reset_busy", {31'd0, busy1}, 32'd0);
    chk("reset_addr", {22'd0, addr1}, 32'd0);
    reset = 1'b1;
    step(2);

    // Basic pass and address wrap on the second instance
    regs[5] = 32'hDEADBEEF;
    exp_snap[5] = 32'hDEADBEEF;
    clear_counts();
    start_pulse();
    wait_done();
    chk("basic_writes", 32'(writes), 32'd512);
    chk("basic_done_cyc", 32'(done_cyc), 32'd545);
    for (int i = 0; i < 16; i++) chk("line5", {24'd0, mem[80 + i]}, {24'd0, exp5[i]});
    chk("wrap_pos", 32'(wrap_pos), 32'd24);
    chk("wrap_data", {24'd0, mem2[0]}, 32'h30);

    // Backpressure at line 0 column 6
    clear_counts();
    start_pulse();
    step(7);
    char_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_addr", {22'd0, addr1}, 32'd6);
      chk("stall_we", {31'd0, we1}, 32'd1);
      chk("stall_data", {24'd0, data1}, 32'h30);
      step(1);
    end
    char_ready = 1'b1;
    wait_done();
    chk("bp_writes", 32'(writes), 32'd512);
    chk("bp_done_cyc", 32'(done_cyc), 32'd548);

    // Snapshot coherence with start held for back-to-back passes
    regs[3] = 32'h11111111;
    exp_snap[3] = 32'h11111111;
    clear_counts();
    start = 1'b1;
    step(1);
    step(59);
    regs[3] = 32'h22222222;
    step(240);
    for (int i = 0; i < 8; i++) chk("snap_a", {24'd0, mem[52 + i]}, 32'h31);
    exp_snap[3] = 32'h22222222;
    step(248);
    chk("b2b_busy", {31'd0, busy1}, 32'd1);
    start = 1'b0;
    wait_done();
    chk("b2b_done_cnt", 32'(done_cnt), 32'd2);
    chk("b2b_writes", 32'(writes), 32'd1024);
    for (int i = 0; i < 8; i++) chk("snap_b", {24'd0, mem[52 + i]}, 32'h32);

    // Start while busy is ignored
    clear_counts();
    step(9);
    start_pulse();
    step(289);
    start_pulse();
    wait_done();
    step(20);
    chk("sib_done_cnt", 32'(done_cnt), 32'd1);
    chk("sib_writes", 32'(writes), 32'd512);
    chk("sib_idle", {31'd0, busy1}, 32'd0);

    // Asynchronous reset mid-pass
    clear_counts();
    start_pulse();
    step(199);
    #1;
    reset = 1'b0;
    #1;
    chk("async_we", {31'd0, we1}, 32'd0);
    chk("async_busy", {31'd0, busy1}, 32'd0);
    chk("async_we2", {31'd0, we2}, 32'd0);
    step(2);
    reset = 1'b1;
    step(5);
    chk("post_rst_idle", {31'd0, busy1}, 32'd0);
    chk("post_rst_done", 32'(done_cnt), 32'd0);
    clear_counts();
    start_pulse();
    wait_done();
    chk("fresh_first_addr", 32'(first_addr), 32'd0);
    chk("fresh_writes", 32'(writes), 32'd512);
    chk("fresh_done_cyc", 32'(done_cyc), 32'd545);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
